// File: rtl/fp_ctrl_pkg.sv
// Shared types and defaults for the floating-point add/sub sequencing controller.
package fp_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    EXP      = 4'd1,
    ALIGN    = 4'd2,
    ADD      = 4'd3,
    EXP_SET  = 4'd4,
    EXP_LD   = 4'd5,
    NORM_SET = 4'd6,
    NORM_LD  = 4'd7,
    RND_CHK  = 4'd8,
    OVF_SET  = 4'd9,
    OVF_LD   = 4'd10,
    DONE     = 4'd11
  } fp_state_e;

  localparam int FRAC_W_DEF    = 26;
  localparam int ALIGN_MAX_DEF = 31;

  // Alignment shift amount clipped to what the shifter can express.
  function automatic logic [4:0] sat_align(input logic [7:0] diff, input int align_max);
    if (int'(diff) > align_max) return 5'(align_max);
    return diff[4:0];
  endfunction

endpackage

// File: rtl/fp_add_control.sv
// Sequencing FSM driving the FP add/sub datapath controls with a start/done handshake.
// Optional FP_ADD_CTRL_DEBUG_EN adds dbg_state and a saturating busy-cycle counter dbg_cycles.
module fp_add_control
  import fp_ctrl_pkg::*;
#(
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int ALIGN_MAX = ALIGN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sub_op,
  input  logic [7:0] exp_diff,
  input  logic [7:0] lz_count,
  input  logic       carry_dir,
  input  logic       round_ovf,
  output logic       soma_multiplica_small_ula,
  output logic       soma_multiplica_big_ula,
  output logic       subtrador_big_ula,
  output logic       decisor_mux_expoente_escolhido,
  output logic       decisor_mux_saida_big_ula,
  output logic       decisor_shift_right_left,
  output logic       subtrador_Somador_subtrador,
  output logic [4:0] tamanho,
  output logic [4:0] tamanho2,
  output logic [7:0] tamanho3,
  output logic       load,
  output logic       busy,
  output logic       done,
  output logic       zero_res
`ifdef FP_ADD_CTRL_DEBUG_EN
  ,
  output logic [3:0] dbg_state,
  output logic [7:0] dbg_cycles
`endif
);

  fp_state_e  state;
  logic       sub_q;
  logic [7:0] diff_q;
  logic [7:0] lz_q;
  logic       dir_q;
  logic       rnd_wait;
  logic       zero_hit;

  assign zero_hit = (int'(lz_count) >= FRAC_W) && !carry_dir;

  // Outputs are registered alongside the state transition so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                          <= IDLE;
      sub_q                          <= 1'b0;
      diff_q                         <= '0;
      lz_q                           <= '0;
      dir_q                          <= 1'b0;
      rnd_wait                       <= 1'b0;
      soma_multiplica_small_ula      <= 1'b0;
      soma_multiplica_big_ula        <= 1'b0;
      subtrador_big_ula              <= 1'b0;
      decisor_mux_expoente_escolhido <= 1'b0;
      decisor_mux_saida_big_ula      <= 1'b0;
      decisor_shift_right_left       <= 1'b0;
      subtrador_Somador_subtrador    <= 1'b0;
      tamanho                        <= '0;
      tamanho2                       <= '0;
      tamanho3                       <= '0;
      load                           <= 1'b0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      zero_res                       <= 1'b0;
    end else begin
      load                      <= 1'b0;
      done                      <= 1'b0;
      zero_res                  <= 1'b0;
      soma_multiplica_small_ula <= 1'b0;
      soma_multiplica_big_ula   <= 1'b0;
      subtrador_big_ula         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state                          <= EXP;
          sub_q                          <= sub_op;
          busy                           <= 1'b1;
          soma_multiplica_small_ula      <= 1'b1;
          decisor_mux_expoente_escolhido <= 1'b0;
          decisor_mux_saida_big_ula      <= 1'b0;
          decisor_shift_right_left       <= 1'b0;
          subtrador_Somador_subtrador    <= 1'b0;
          tamanho                        <= '0;
          tamanho2                       <= '0;
          tamanho3                       <= '0;
        end
        EXP: state <= ALIGN;
        ALIGN: begin
          state                   <= ADD;
          diff_q                  <= exp_diff;
          tamanho                 <= sat_align(exp_diff, ALIGN_MAX);
          soma_multiplica_big_ula <= 1'b1;
          subtrador_big_ula       <= sub_q;
        end
        ADD: begin
          lz_q  <= lz_count;
          dir_q <= carry_dir;
          if (zero_hit) begin
            state    <= DONE;
            done     <= 1'b1;
            zero_res <= 1'b1;
          end else begin
            state                          <= EXP_SET;
            decisor_mux_expoente_escolhido <= 1'b0;
            subtrador_Somador_subtrador    <= 1'b0;
            tamanho3                       <= diff_q;
          end
        end
        EXP_SET: begin
          state <= EXP_LD;
          load  <= 1'b1;
        end
        EXP_LD: begin
          state                          <= NORM_SET;
          decisor_mux_expoente_escolhido <= 1'b1;
          decisor_mux_saida_big_ula      <= 1'b0;
          if (dir_q) begin
            decisor_shift_right_left    <= 1'b0;
            tamanho2                    <= 5'd1;
            tamanho3                    <= 8'd1;
            subtrador_Somador_subtrador <= 1'b0;
          end else begin
            decisor_shift_right_left    <= 1'b1;
            tamanho2                    <= lz_q[4:0];
            tamanho3                    <= lz_q;
            subtrador_Somador_subtrador <= 1'b1;
          end
        end
        NORM_SET: begin
          state <= NORM_LD;
          load  <= 1'b1;
        end
        NORM_LD: begin
          state    <= RND_CHK;
          rnd_wait <= 1'b0;
        end
        // The rounding stage reflects the normalised latch one cycle after the
        // strobe, so round_ovf is sampled on the second RND_CHK cycle.
        RND_CHK: begin
          if (!rnd_wait) begin
            rnd_wait <= 1'b1;
          end else if (round_ovf) begin
            state                          <= OVF_SET;
            decisor_mux_saida_big_ula      <= 1'b1;
            decisor_shift_right_left       <= 1'b0;
            tamanho2                       <= 5'd1;
            decisor_mux_expoente_escolhido <= 1'b1;
            subtrador_Somador_subtrador    <= 1'b0;
            tamanho3                       <= 8'd1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        OVF_SET: begin
          state <= OVF_LD;
          load  <= 1'b1;
        end
        OVF_LD: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP_ADD_CTRL_DEBUG_EN
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n)                       dbg_cycles <= '0;
    else if (state == IDLE && start)  dbg_cycles <= '0;
    else if (busy && dbg_cycles != 8'hFF) dbg_cycles <= dbg_cycles + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fp_add_control.sv
// Self-checking bench for fp_add_control: directed scenarios plus randomized ops vs a behavioural model.
module tb_fp_add_control;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub_op = 1'b0;
  logic [7:0] exp_diff = '0, lz_count = '0;
  logic       carry_dir = 1'b0, round_ovf = 1'b0;
  logic       soma_multiplica_small_ula, soma_multiplica_big_ula, subtrador_big_ula;
  logic       decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula, decisor_shift_right_left;
  logic       subtrador_Somador_subtrador;
  logic [4:0] tamanho, tamanho2;
  logic [7:0] tamanho3;
  logic       load, busy, done, zero_res;

  fp_add_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub_op(sub_op), .exp_diff(exp_diff),
    .lz_count(lz_count), .carry_dir(carry_dir), .round_ovf(round_ovf),
    .soma_multiplica_small_ula(soma_multiplica_small_ula),
    .soma_multiplica_big_ula(soma_multiplica_big_ula), .subtrador_big_ula(subtrador_big_ula),
    .decisor_mux_expoente_escolhido(decisor_mux_expoente_escolhido),
    .decisor_mux_saida_big_ula(decisor_mux_saida_big_ula),
    .decisor_shift_right_left(decisor_shift_right_left),
    .subtrador_Somador_subtrador(subtrador_Somador_subtrador),
    .tamanho(tamanho), .tamanho2(tamanho2), .tamanho3(tamanho3),
    .load(load), .busy(busy), .done(done), .zero_res(zero_res)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct packed {
    logic       mux_exp;
    logic       mux_saida;
    logic       shift;
    logic       subsom;
    logic [4:0] t2;
    logic [7:0] t3;
  } snap_t;

  snap_t snaps [3];
  int    o_lat, o_loads, o_small;
  bit    o_consec, o_busy_bad, o_unstable, o_subbig_bad, o_zres;
  logic [4:0] o_tam;

  function automatic snap_t cur_snap();
    return '{mux_exp: decisor_mux_expoente_escolhido, mux_saida: decisor_mux_saida_big_ula,
             shift: decisor_shift_right_left, subsom: subtrador_Somador_subtrador,
             t2: tamanho2, t3: tamanho3};
  endfunction

  // Reference model: result shape from the sequencing rules.
  function automatic bit m_zero(input logic [7:0] lz, input bit dir);
    return (int'(lz) >= 26) && !dir;
  endfunction
  function automatic int m_lat(input logic [7:0] lz, input bit dir, input bit ovf);
    if (m_zero(lz, dir)) return 4;
    return ovf ? 12 : 10;
  endfunction
  function automatic int m_loads(input logic [7:0] lz, input bit dir, input bit ovf);
    if (m_zero(lz, dir)) return 0;
    return ovf ? 3 : 2;
  endfunction
  function automatic snap_t m_norm(input logic [7:0] lz, input bit dir);
    if (dir) return '{mux_exp: 1'b1, mux_saida: 1'b0, shift: 1'b0, subsom: 1'b0, t2: 5'd1, t3: 8'd1};
    return '{mux_exp: 1'b1, mux_saida: 1'b0, shift: 1'b1, subsom: 1'b1, t2: lz[4:0], t3: lz};
  endfunction
  function automatic snap_t m_ovf();
    return '{mux_exp: 1'b1, mux_saida: 1'b1, shift: 1'b0, subsom: 1'b0, t2: 5'd1, t3: 8'd1};
  endfunction

  // Drives one operation and records what the controller did until done (bounded).
  task automatic run_op(input bit s, input logic [7:0] d, input logic [7:0] lz,
                        input bit dir, input bit ovf, input bit hold);
    snap_t prev;
    bit    prev_load;
    @(negedge clk);
    start = 1'b1; sub_op = s; exp_diff = d; lz_count = lz; carry_dir = dir; round_ovf = ovf;
    o_lat = -1; o_loads = 0; o_small = 0; o_consec = 0; o_busy_bad = 0; o_unstable = 0;
    o_subbig_bad = 0; o_zres = 0; o_tam = '0; prev_load = 0;
    prev = cur_snap();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy !== 1'b1) o_busy_bad = 1;
      if (soma_multiplica_small_ula) o_small++;
      if (soma_multiplica_big_ula && subtrador_big_ula !== s) o_subbig_bad = 1;
      if (load) begin
        if (prev_load) o_consec = 1;
        if (cur_snap() !== prev) o_unstable = 1;
        if (o_loads < 3) snaps[o_loads] = cur_snap();
        o_loads++;
      end
      prev_load = load;
      prev = cur_snap();
      if (done) begin
        o_lat = c; o_zres = zero_res; o_tam = tamanho;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({soma_multiplica_small_ula, soma_multiplica_big_ula, subtrador_big_ula,
         decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula, decisor_shift_right_left,
         subtrador_Somador_subtrador, tamanho, tamanho2, tamanho3, load, busy, done, zero_res} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs want all 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_normal();
    run_op(1'b0, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_lat !== 10) begin errors++; $display("FAIL normal_latency got %0d want 10", o_lat); end
    checks++; if (o_tam !== 5'd3) begin errors++; $display("FAIL normal_tamanho got %0d want 3", o_tam); end
    checks++; if (o_loads !== 2) begin errors++; $display("FAIL normal_loads got %0d want 2", o_loads); end
    checks++;
    if (snaps[1].t2 !== 5'd1 || snaps[1].t3 !== 8'd1 || snaps[1].shift !== 1'b0) begin
      errors++; $display("FAIL normal_norm_set got t2=%0d t3=%0d shift=%0b want 1 1 0",
                         snaps[1].t2, snaps[1].t3, snaps[1].shift);
    end
    checks++; if (o_zres !== 1'b0) begin errors++; $display("FAIL normal_zero_res got %0b want 0", o_zres); end
  endtask

  task automatic test_saturation();
    run_op(1'b0, 8'd40, 8'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (o_tam !== 5'd31) begin errors++; $display("FAIL sat_tamanho got %0d want 31", o_tam); end
    checks++; if (snaps[0].t3 !== 8'd40) begin errors++; $display("FAIL sat_tamanho3 got %0d want 40", snaps[0].t3); end
  endtask

  task automatic test_ovf();
    run_op(1'b0, 8'd5, 8'd4, 1'b0, 1'b1, 1'b0);
    checks++; if (o_lat !== 12) begin errors++; $display("FAIL ovf_latency got %0d want 12", o_lat); end
    checks++; if (o_loads !== 3) begin errors++; $display("FAIL ovf_loads got %0d want 3", o_loads); end
    checks++;
    if (snaps[1].t2 !== 5'd4 || snaps[1].t3 !== 8'd4 || snaps[1].shift !== 1'b1 || snaps[1].subsom !== 1'b1) begin
      errors++; $display("FAIL ovf_norm_left got t2=%0d t3=%0d shift=%0b sub=%0b want 4 4 1 1",
                         snaps[1].t2, snaps[1].t3, snaps[1].shift, snaps[1].subsom);
    end
    checks++;
    if (snaps[2].mux_saida !== 1'b1 || snaps[2].t2 !== 5'd1 || snaps[2].t3 !== 8'd1) begin
      errors++; $display("FAIL ovf_set got saida=%0b t2=%0d t3=%0d want 1 1 1",
                         snaps[2].mux_saida, snaps[2].t2, snaps[2].t3);
    end
    checks++; if (o_consec !== 1'b0) begin errors++; $display("FAIL ovf_load_consec got 1 want 0"); end
  endtask

  task automatic test_zero();
    run_op(1'b1, 8'd7, 8'd26, 1'b0, 1'b1, 1'b0);
    checks++; if (o_lat !== 4) begin errors++; $display("FAIL zero_latency got %0d want 4", o_lat); end
    checks++; if (o_zres !== 1'b1) begin errors++; $display("FAIL zero_res got %0b want 1", o_zres); end
    checks++; if (o_loads !== 0) begin errors++; $display("FAIL zero_loads got %0d want 0", o_loads); end
    checks++; if (o_subbig_bad !== 1'b0) begin errors++; $display("FAIL zero_sub_big got mismatch want sub_op"); end
  endtask

  task automatic test_back_to_back();
    int k;
    run_op(1'b0, 8'd9, 8'd1, 1'b1, 1'b0, 1'b1);
    checks++; if (o_lat !== 10) begin errors++; $display("FAIL b2b_first_latency got %0d want 10", o_lat); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%0b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%0b want 1", busy); end
    k = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin k = c; break; end
    end
    checks++; if (k !== 9) begin errors++; $display("FAIL b2b_second_done got %0d want 9", k); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ndone;
    @(negedge clk);
    start = 1'b1; sub_op = 1'b0; exp_diff = 8'd3; lz_count = 8'd0; carry_dir = 1'b1; round_ovf = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (soma_multiplica_big_ula !== 1'b1) begin
      errors++; $display("FAIL abort_in_add got soma_big=%0b want 1", soma_multiplica_big_ula);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({soma_multiplica_big_ula, tamanho, tamanho3, load, busy, done, zero_res} !== '0) begin
      errors++; $display("FAIL abort_outputs got nonzero outputs want all 0");
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin @(negedge clk); if (done || busy) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_random();
    bit s, dir, ovf;
    logic [7:0] d, lz;
    snap_t en;
    int tam_exp;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom); dir = 1'($urandom); ovf = 1'($urandom);
      d = 8'($urandom);
      lz = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(24, 60)) : 8'($urandom_range(0, 31));
      run_op(s, d, lz, dir, ovf, 1'b0);
      tam_exp = (int'(d) > 31) ? 31 : int'(d);
      checks++; if (o_lat !== m_lat(lz, dir, ovf)) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, o_lat, m_lat(lz, dir, ovf)); end
      checks++; if (o_loads !== m_loads(lz, dir, ovf)) begin errors++; $display("FAIL rnd%0d_loads got %0d want %0d", i, o_loads, m_loads(lz, dir, ovf)); end
      checks++; if (o_zres !== m_zero(lz, dir)) begin errors++; $display("FAIL rnd%0d_zero_res got %0b want %0b", i, o_zres, m_zero(lz, dir)); end
      checks++; if (int'(o_tam) !== tam_exp) begin errors++; $display("FAIL rnd%0d_tamanho got %0d want %0d", i, o_tam, tam_exp); end
      checks++;
      if ({o_consec, o_unstable, o_busy_bad, o_subbig_bad} !== 4'b0 || o_small !== 1) begin
        errors++; $display("FAIL rnd%0d_protocol got consec=%0b unstable=%0b busy=%0b sub=%0b small=%0d want 0 0 0 0 1",
                           i, o_consec, o_unstable, o_busy_bad, o_subbig_bad, o_small);
      end
      if (!m_zero(lz, dir) && o_loads >= 2) begin
        checks++;
        if (snaps[0].t3 !== d || snaps[0].mux_exp !== 1'b0 || snaps[0].subsom !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_exp_set got t3=%0d mux=%0b sub=%0b want %0d 0 0", i,
                             snaps[0].t3, snaps[0].mux_exp, snaps[0].subsom, d);
        end
        en = m_norm(lz, dir);
        checks++; if (snaps[1] !== en) begin errors++; $display("FAIL rnd%0d_norm_set got %h want %h", i, snaps[1], en); end
        if (ovf && o_loads >= 3) begin
          en = m_ovf();
          checks++; if (snaps[2] !== en) begin errors++; $display("FAIL rnd%0d_ovf_set got %h want %h", i, snaps[2], en); end
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_after_done got done=%0b busy=%0b want 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturation();
    test_ovf();
    test_zero();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_control.md
Name: fp_add_control

Overview:
- Sequencing FSM that drives the floating-point add/sub datapath's control inputs, replacing hand-driven testbench stimulus.
- Sits directly upstream of the datapath: it produces every control word and shift amount, consumes the datapath status outputs, and reports completion to the issuing logic through a start/done handshake.

Parameters:
- FRAC_W, 26, width of the internal fraction path; a leading-zero count of FRAC_W or more means a zero result.
- ALIGN_MAX, 31, saturation value for the alignment shift amount.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- sub_op  in  1  1 = effective subtraction
- exp_diff  in  8  registered exponent difference from datapath (saida_registrador)
- lz_count  in  8  normaliser shift count (tamanhoShift)
- carry_dir  in  1  carry-out / right-shift flag (directionShift)
- round_ovf  in  1  rounding overflow (overflow)
- soma_multiplica_small_ula, soma_multiplica_big_ula, subtrador_big_ula  out  1 each  datapath controls
- decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula, decisor_shift_right_left, subtrador_Somador_subtrador  out  1 each  datapath controls
- tamanho  out  5  alignment shift
- tamanho2  out  5  normalise shift
- tamanho3  out  8  exponent adjust
- load  out  1  rounding-stage latch strobe
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- zero_res  out  1  result is zero; valid while done is high

Behaviour:
- Outputs: all registered. Reset (rst_n = 0 at a clk edge) forces state IDLE and every output to 0. Reset mid-operation aborts with no done pulse.
- IDLE:
  - busy = 0.
  - start = 1 → EXP. sub_op is latched into sub_q here.
  - start while busy is ignored.
- EXP: soma_multiplica_small_ula = 1; datapath register captures the difference at the end of this cycle.
- ALIGN:
  - diff_q <= exp_diff.
  - tamanho <= min(exp_diff, ALIGN_MAX).
- ADD:
  - soma_multiplica_big_ula = 1 and subtrador_big_ula = sub_q.
  - At the exit edge, lz_q <= lz_count and dir_q <= carry_dir.
  - If lz_q >= FRAC_W and dir_q = 0 → DONE with zero_res = 1; otherwise → EXP_SET.
- EXP_SET:
  - decisor_mux_expoente_escolhido = 0, subtrador_Somador_subtrador = 0.
  - tamanho3 = diff_q.
- EXP_LD: load = 1 for exactly one cycle; controls held from EXP_SET.
- NORM_SET:
  - decisor_mux_expoente_escolhido = 1, decisor_mux_saida_big_ula = 0.
  - If dir_q = 1: decisor_shift_right_left = 0, tamanho2 = 1, tamanho3 = 1, subtrador_Somador_subtrador = 0.
  - If dir_q = 0: decisor_shift_right_left = 1, tamanho2 = lz_q[4:0], tamanho3 = lz_q, subtrador_Somador_subtrador = 1.
- NORM_LD: load = 1 for one cycle; controls held.
- RND_CHK: sample round_ovf. If 1 → OVF_SET, else → DONE.
- OVF_SET:
  - decisor_mux_saida_big_ula = 1, decisor_shift_right_left = 0, tamanho2 = 1.
  - decisor_mux_expoente_escolhido = 1, subtrador_Somador_subtrador = 0, tamanho3 = 1.
- OVF_LD: load = 1 for one cycle, then → DONE.
- DONE:
  - done = 1 for one cycle, then → IDLE.
  - busy is high in every state except IDLE.
- Timing:
  - Latency from the start-sample edge to done high is 10 cycles, or 12 with rounding overflow. A zero result takes 4 cycles.
  - load is never high in two consecutive cycles, and always follows at least one cycle of stable controls.

Optional Feature:
- Macro FP_ADD_CTRL_DEBUG_EN.
- Defined:
  - adds output dbg_state[3:0] (current state encoding);
  - adds output dbg_cycles[7:0], which clears on start and increments each busy cycle, saturating at 255.
- Undefined: these ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package fp_ctrl_pkg:
  - state enum: IDLE, EXP, ALIGN, ADD, EXP_SET, EXP_LD, NORM_SET, NORM_LD, RND_CHK, OVF_SET, OVF_LD, DONE;
  - constants FRAC_W_DEF = 26 and ALIGN_MAX_DEF = 31.
- No sub-module; a single FSM with registered output decode.

Test Plan:
- Reset pulse mid-ADD → next cycle state IDLE, all outputs 0, no done.
- start, exp_diff = 3, lz_count = 0, carry_dir = 1, round_ovf = 0 → tamanho = 3; in NORM_SET tamanho2 = 1, tamanho3 = 1, right shift; done at cycle 10.
- exp_diff = 40 → tamanho saturates to 31.
- carry_dir = 0, lz_count = 4, round_ovf = 1 → left shift by 4, subtract 4; OVF_SET path taken; done at cycle 12; exactly 3 load pulses.
- sub_op = 1, lz_count = 26, carry_dir = 0 → done at cycle 4 with zero_res = 1; no load pulses.
- start held high through the whole operation and into DONE → only one operation runs; a new start is accepted in the IDLE cycle after DONE.
